// File: rtl/timer_bus_arbiter_pkg.sv
// Shared types and defaults for the machine-timer bus arbiter: FSM state encoding,
// the latched request bundle and parameter defaults.
package timer_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } tarb_state_t;

  typedef struct packed {
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } tarb_req_t;

  localparam int TARB_NREQ_DEFAULT    = 2;
  localparam int TARB_TIMEOUT_DEFAULT = 15;
  // Wide enough for the largest allowed TIMEOUT (255).
  localparam int TARB_CNT_W           = 8;

endpackage

// File: rtl/timer_bus_arbiter_rr_picker.sv
// Combinational round-robin priority encoder: returns the first set request bit
// found searching upward from ptr, wrapping past NREQ-1 back to 0.
module timer_bus_arbiter_rr_picker #(
  parameter int NREQ  = 2,
  parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] grant,
  output logic             any
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    grant = '0;
    any   = 1'b0;
    idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = IDX_W'((int'(ptr) + i) % NREQ);
      if (!any && req[idx]) begin
        any   = 1'b1;
        grant = idx;
      end
    end
  end

endmodule

// File: rtl/timer_bus_arbiter.sv
// Shares the machine-timer register port between NREQ requesters: round-robin grant,
// one transaction in flight, one-cycle timer_valid pulse, timeout answers with err=1.
module timer_bus_arbiter
  import timer_bus_arbiter_pkg::*;
#(
  parameter int NREQ    = TARB_NREQ_DEFAULT,
  parameter int TIMEOUT = TARB_TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_instr,
  input  logic [NREQ*32-1:0] req_addr,
  input  logic [NREQ*32-1:0] req_wdata,
  input  logic [NREQ*4-1:0] req_wstrb,
  output logic [31:0]       req_rdata,
  output logic [NREQ-1:0]   req_ready,
  output logic              req_err,
  output logic              timer_valid,
  output logic              timer_instr,
  output logic [31:0]       timer_addr,
  output logic [31:0]       timer_wdata,
  output logic [3:0]        timer_wstrb,
  input  logic [31:0]       timer_rdata,
  input  logic              timer_ready
);

  localparam int                    IDX_W    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NREQ - 1);
  localparam logic [TARB_CNT_W-1:0] CNT_LAST = TARB_CNT_W'(TIMEOUT - 1);

  tarb_state_t           state_q, state_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [IDX_W-1:0]      grant_q, grant_d;
  tarb_req_t             fields_q, fields_d;
  logic [TARB_CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic [IDX_W-1:0]      pick_idx;
  logic                  pick_any;
  tarb_req_t             pick_fields;

  timer_bus_arbiter_rr_picker #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (pick_idx),
    .any   (pick_any)
  );

  // Request bundle of the requester the picker would grant this cycle.
  always_comb begin
    pick_fields = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_idx == IDX_W'(i)) begin
        pick_fields.instr = req_instr[i];
        pick_fields.addr  = req_addr[i*32 +: 32];
        pick_fields.wdata = req_wdata[i*32 +: 32];
        pick_fields.wstrb = req_wstrb[i*4 +: 4];
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments, so every flop updates from pre-edge values.
    if (!rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      grant_q  <= '0;
      fields_q <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      fields_q <= fields_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // A timer_ready arriving on the final wait cycle still beats the timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_any) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (timer_ready || (cnt_q == CNT_LAST)) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    fields_d = fields_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d  = pick_idx;
          fields_d = pick_fields;
        end
      end
      ISSUE: cnt_d = '0;
      WAIT: begin
        if (timer_ready) begin
          rdata_d = timer_rdata;
          err_d   = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: ptr_d = (grant_q == LAST_IDX) ? '0 : grant_q + 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    timer_valid = (state_q == ISSUE);
    req_ready   = '0;
    if (state_q == RESP) req_ready[grant_q] = 1'b1;
  end

  // Timer-side fields come from the latched bundle, never from live requester inputs.
  assign timer_instr = fields_q.instr;
  assign timer_addr  = fields_q.addr;
  assign timer_wdata = fields_q.wdata;
  assign timer_wstrb = fields_q.wstrb;
  assign req_rdata   = rdata_q;
  assign req_err     = err_q;

endmodule

// File: tb/tb_timer_bus_arbiter.sv
// Scoreboard bench for timer_bus_arbiter: stimulus pushes expected timer accesses and
// responses (with cycle numbers); independent monitors pop and compare.
module tb_timer_bus_arbiter;

  localparam int NREQ    = 2;
  localparam int TIMEOUT = 15;

  logic         clk, rst;
  logic [1:0]   req_valid, req_instr;
  logic [63:0]  req_addr, req_wdata;
  logic [7:0]   req_wstrb;
  logic [31:0]  req_rdata;
  logic [1:0]   req_ready;
  logic         req_err;
  logic         timer_valid, timer_instr;
  logic [31:0]  timer_addr, timer_wdata;
  logic [3:0]   timer_wstrb;
  logic [31:0]  timer_rdata;
  logic         timer_ready;

  typedef struct {
    logic [1:0]  ready;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } resp_t;

  typedef struct {
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          cyc;
  } tacc_t;

  resp_t exp_resp[$];
  tacc_t exp_tacc[$];
  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  int    stray_a = -1;
  int    stray_b = -1;

  timer_bus_arbiter #(
    .NREQ    (NREQ),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_instr   (req_instr),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_wstrb   (req_wstrb),
    .req_rdata   (req_rdata),
    .req_ready   (req_ready),
    .req_err     (req_err),
    .timer_valid (timer_valid),
    .timer_instr (timer_instr),
    .timer_addr  (timer_addr),
    .timer_wdata (timer_wdata),
    .timer_wstrb (timer_wstrb),
    .timer_rdata (timer_rdata),
    .timer_ready (timer_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] tmr_read(input logic [31:0] a);
    case (a)
      32'h0:   return 32'hCAFE_0000;
      32'h4:   return 32'h00C0_FFEE;
      32'h8:   return 32'h0000_1234;
      32'hC:   return 32'h0BAD_F00D;
      default: return 32'h5A5A_5A5A;
    endcase
  endfunction

  // Timer model and timer-side monitor: offset 0x10 is unmapped and never acknowledged,
  // writes return 0, and stray_a/stray_b inject unsolicited ready pulses.
  initial begin
    logic        pend;
    logic [31:0] pdata;
    tacc_t       e;
    pend        = 1'b0;
    pdata       = '0;
    timer_ready = 1'b0;
    timer_rdata = '0;
    forever begin
      @(negedge clk);
      pend = 1'b0;
      if (timer_valid) begin
        if (exp_tacc.size() == 0) begin
          check("tmr_unexpected_pulse", 64'(timer_addr), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = exp_tacc.pop_front();
          check("tmr_ctrl", 64'({timer_instr, timer_wstrb, timer_addr}),
                64'({e.instr, e.wstrb, e.addr}));
          check("tmr_wdata", 64'(timer_wdata), 64'(e.wdata));
          check("tmr_cycle", 64'(cyc), 64'(e.cyc));
        end
        if (timer_addr != 32'h10) begin
          pend  = 1'b1;
          pdata = (timer_wstrb != 4'h0) ? 32'h0 : tmr_read(timer_addr);
        end
      end
      @(posedge clk);
      #1;
      timer_ready = pend || (cyc == stray_a) || (cyc == stray_b);
      timer_rdata = pend ? pdata : (timer_ready ? 32'hFFFF_FFFF : 32'h0);
    end
  end

  // Response monitor.
  initial begin
    resp_t e;
    forever begin
      @(negedge clk);
      if (req_ready != 2'b00) begin
        if (exp_resp.size() == 0) begin
          check("resp_unexpected", 64'(req_ready), 64'h0);
        end else begin
          e = exp_resp.pop_front();
          check("resp_ready", 64'(req_ready), 64'(e.ready));
          check("resp_data", 64'({req_err, req_rdata}), 64'({e.err, e.rdata}));
          check("resp_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
    end
  end

  task automatic drive(input int i, input logic instr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wstrb);
    req_instr[i]          = instr;
    req_addr[i*32 +: 32]  = addr;
    req_wdata[i*32 +: 32] = wdata;
    req_wstrb[i*4 +: 4]   = wstrb;
    req_valid[i]          = 1'b1;
  endtask

  task automatic exp_t(input logic instr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb, input int c);
    tacc_t e;
    e.instr = instr;
    e.addr  = addr;
    e.wdata = wdata;
    e.wstrb = wstrb;
    e.cyc   = c;
    exp_tacc.push_back(e);
  endtask

  task automatic exp_r(input logic [1:0] ready, input logic [31:0] rdata, input logic err,
                       input int c);
    resp_t e;
    e.ready = ready;
    e.rdata = rdata;
    e.err   = err;
    e.cyc   = c;
    exp_resp.push_back(e);
  endtask

  // Requesters hold valid until their ready pulse, then drop it.
  task automatic serve(input logic [1:0] mask, input int budget);
    logic [1:0] done;
    done = 2'b00;
    for (int n = 0; n < budget && done != mask; n++) begin
      @(negedge clk);
      done      = done | (req_ready & mask);
      req_valid = req_valid & ~req_ready;
    end
    check("serve_done", 64'(done), 64'(mask));
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_tmr_ctrl"}, 64'({timer_valid, timer_instr, timer_wstrb, timer_addr}), 64'h0);
    check({tag, "_tmr_wdata"}, 64'(timer_wdata), 64'h0);
    check({tag, "_resp"}, 64'({req_ready, req_err, req_rdata}), 64'h0);
  endtask

  initial begin
    int         c0;
    int         n;
    logic [1:0] rel;
    rst       = 1'b0;
    req_valid = '0;
    req_instr = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_wstrb = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Single read, pointer moves to 1.
    c0 = cyc;
    exp_t(1'b0, 32'h8, 32'h0, 4'h0, c0 + 1);
    exp_r(2'b01, 32'h0000_1234, 1'b0, c0 + 3);
    drive(0, 1'b0, 32'h8, 32'h0, 4'h0);
    serve(2'b01, 20);

    // Lone req1 instruction fetch, pointer back to 0.
    c0 = cyc;
    exp_t(1'b1, 32'hC, 32'h0, 4'h0, c0 + 1);
    exp_r(2'b10, 32'h0BAD_F00D, 1'b0, c0 + 3);
    drive(1, 1'b1, 32'hC, 32'h0, 4'h0);
    serve(2'b10, 20);

    // Contention with pointer 0: req0 then req1.
    c0 = cyc;
    exp_t(1'b0, 32'h0, 32'h0, 4'h0, c0 + 1);
    exp_r(2'b01, 32'hCAFE_0000, 1'b0, c0 + 3);
    exp_t(1'b0, 32'h4, 32'h0, 4'h0, c0 + 5);
    exp_r(2'b10, 32'h00C0_FFEE, 1'b0, c0 + 7);
    drive(0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1, 1'b0, 32'h4, 32'h0, 4'h0);
    serve(2'b11, 30);

    // Lone req0 moves pointer to 1, then contention serves req1 first.
    c0 = cyc;
    exp_t(1'b0, 32'h8, 32'h0, 4'h0, c0 + 1);
    exp_r(2'b01, 32'h0000_1234, 1'b0, c0 + 3);
    drive(0, 1'b0, 32'h8, 32'h0, 4'h0);
    serve(2'b01, 20);
    c0 = cyc;
    exp_t(1'b0, 32'h0, 32'h0, 4'h0, c0 + 1);
    exp_r(2'b10, 32'hCAFE_0000, 1'b0, c0 + 3);
    exp_t(1'b0, 32'h4, 32'h0, 4'h0, c0 + 5);
    exp_r(2'b01, 32'h00C0_FFEE, 1'b0, c0 + 7);
    drive(0, 1'b0, 32'h4, 32'h0, 4'h0);
    drive(1, 1'b0, 32'h0, 32'h0, 4'h0);
    serve(2'b11, 30);

    // Write with stray timer_ready during RESP and the following idle cycle.
    c0      = cyc;
    stray_a = c0 + 3;
    stray_b = c0 + 4;
    exp_t(1'b0, 32'h0, 32'hDEAD_BEEF, 4'hF, c0 + 1);
    exp_r(2'b01, 32'h0, 1'b0, c0 + 3);
    drive(0, 1'b0, 32'h0, 32'hDEAD_BEEF, 4'hF);
    serve(2'b01, 20);
    repeat (3) @(posedge clk);
    #1;

    // Timeout on unmapped offset: err=1 at request+2+TIMEOUT, single timer pulse.
    c0 = cyc;
    exp_t(1'b0, 32'h10, 32'h0, 4'h0, c0 + 1);
    exp_r(2'b10, 32'h0, 1'b1, c0 + 2 + TIMEOUT);
    drive(1, 1'b0, 32'h10, 32'h0, 4'h0);
    serve(2'b10, 40);

    // Reset while req1 waits: no response, pointer 0, so req0 is re-granted first.
    c0 = cyc;
    exp_t(1'b0, 32'h8, 32'h0, 4'h0, c0 + 1);
    exp_r(2'b01, 32'h0000_1234, 1'b0, c0 + 3);
    drive(0, 1'b0, 32'h8, 32'h0, 4'h0);
    serve(2'b01, 20);
    c0 = cyc;
    exp_t(1'b0, 32'h10, 32'h0, 4'h0, c0 + 1);
    exp_t(1'b0, 32'h4, 32'h0, 4'h0, c0 + 7);
    exp_r(2'b01, 32'h00C0_FFEE, 1'b0, c0 + 9);
    exp_t(1'b0, 32'h10, 32'h0, 4'h0, c0 + 11);
    exp_r(2'b10, 32'h0, 1'b1, c0 + 12 + TIMEOUT);
    drive(0, 1'b0, 32'h4, 32'h0, 4'h0);
    drive(1, 1'b0, 32'h10, 32'h0, 4'h0);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check_zero_outputs("midreset");
    serve(2'b11, 60);

    // Fairness soak: both always valid, 100 grants alternate starting with req0.
    c0 = cyc;
    for (int k = 0; k < 100; k++) begin
      if (k % 2 == 0) begin
        exp_t(1'b0, 32'h0, 32'h0, 4'h0, c0 + 4 * k + 1);
        exp_r(2'b01, 32'hCAFE_0000, 1'b0, c0 + 4 * k + 3);
      end else begin
        exp_t(1'b0, 32'hC, 32'h0, 4'h0, c0 + 4 * k + 1);
        exp_r(2'b10, 32'h0BAD_F00D, 1'b0, c0 + 4 * k + 3);
      end
    end
    drive(0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1, 1'b0, 32'hC, 32'h0, 4'h0);
    n = 0;
    for (int t = 0; t < 500 && n < 100; t++) begin
      @(negedge clk);
      rel       = req_ready;
      req_valid = req_valid & ~rel;
      if (rel != 2'b00) n++;
      @(posedge clk);
      #1;
      if (n < 100) req_valid = req_valid | rel;
    end
    req_valid = '0;
    check("soak_grants", 64'(n), 64'd100);

    repeat (4) @(posedge clk);
    @(negedge clk);
    check("resp_queue_left", 64'(exp_resp.size()), 64'h0);
    check("tmr_queue_left", 64'(exp_tacc.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
